// File: rtl/avalon_copy_master_if.sv
// Avalon-MM master/slave bus bundle used by the word-copy master.
interface avalon_copy_master_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_copy_master.sv
// Avalon-MM master copying a block of 32-bit words from src to dst,
// one read then one write per word, with done/error completion reporting.
module avalon_copy_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  avalon_copy_master_if.master avm
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                misaligned_c;

  // Word index to byte address; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

  assign misaligned_c = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    read_d  = read_q;
    write_d = write_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          count_d = '0;
          busy_d  = 1'b1;
          error_d = misaligned_c;
          if (misaligned_c || (length == '0)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            read_d  = 1'b1;
            be_d    = BE_ALL;
            addr_d  = src_addr;
          end
        end
      end
      RD: begin
        if (!avm.waitrequest) begin
          state_d = WR;
          read_d  = 1'b0;
          write_d = 1'b1;
          wdata_d = avm.readdata;
          addr_d  = word_addr(dst_q, count_q);
        end
      end
      WR: begin
        if (!avm.waitrequest) begin
          count_d = count_q + LEN_W'(1);
          write_d = 1'b0;
          if (count_d == len_q) begin
            state_d = FIN;
            be_d    = '0;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            read_d  = 1'b1;
            addr_d  = word_addr(src_q, count_d);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      read_q  <= read_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.write      = write_q;
  assign avm.writedata  = wdata_q;
  assign avm.byteenable = be_q;
endmodule

// File: doc/avalon_copy_master.md
# avalon_copy_master

Avalon-MM master that copies a block of 32-bit words from a source byte address to a destination byte address on the same system interconnect. It is the initiator counterpart to the on-chip memory slave. It sits beside the Nios II as a second master, is started by a control pulse from a PIO or CPU-side register block, and reports completion with a done pulse and an error flag.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the Avalon master port and of the src/dst inputs.
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; latched on an accepted start.
- dst_addr  in  ADDR_W  destination byte address; latched on an accepted start.
- length  in  LEN_W  number of 32-bit words to copy; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted, inclusive.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; high if the copy was rejected for misalignment.
- avm_address  out  ADDR_W  byte address of the current transfer.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF while a transfer is active; 4'h0 otherwise.
- avm_readdata  in  32  read data; valid in the cycle avm_read is high and avm_waitrequest is low.
- avm_waitrequest  in  1  slave stall.

## Operation
- Reset state: FSM in IDLE; busy, done, error, avm_read and avm_write are 0; avm_address and avm_writedata are 0; avm_byteenable is 0.
- FSM states are IDLE, RD, WR and FIN.
- In IDLE, start=1 latches src, dst and length and clears the word counter.
  - If src_addr[1:0] or dst_addr[1:0] is nonzero, go to FIN with error=1.
  - Otherwise, if length==0, go to FIN with error=0.
  - Otherwise go to RD.
- RD: drive avm_read=1 and avm_address=src+4*count.
  - Hold all master outputs stable while avm_waitrequest=1.
  - When avm_waitrequest=0, capture avm_readdata into the data register and go to WR.
- WR: drive avm_write=1, avm_address=dst+4*count, and avm_writedata equal to the captured word.
  - Hold all master outputs while avm_waitrequest=1.
  - On acceptance, increment count. If count+1==length, go to FIN; otherwise go to RD.
- FIN: assert done=1 for one cycle, then return to IDLE. error holds its value until the next accepted start.
- avm_read and avm_write are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W: wrap-around past the top of the address space is silent and is not an error.
- Overlapping source and destination ranges are copied in ascending order with no overlap protection.
- start while busy is ignored: no latching and no effect on the transfer in progress.
- Reset asserted mid-transfer returns the block to reset state on that clock edge. avm_read and avm_write are low from the next cycle, even if the slave is still stalling.

## Timing
- Cycle 0: start is sampled in IDLE. Cycle 1: the FSM is in RD, busy=1, and avm_read=1.
- With avm_waitrequest held at 0, each word takes exactly 2 cycles (one RD, one WR).
- For length L≥1 and zero wait states, the last write is accepted in cycle 2L and done=1 in cycle 2L+1.
- Each wait-state cycle adds exactly one cycle to the total.
- length==0 or misaligned addresses: done=1 in cycle 1, with no bus activity.
- The block accepts a new start in the cycle after done, back to back.
- Throughput is one word per 2 cycles at best. There are no pipelined reads and readdatavalid is not used.

## Test plan
- Copy with no wait states: src=0x1000, dst=0x2000, L=4, memory model holds 0xA0..0xA3. Required: reads at 0x1000/04/08/0C and writes of 0xA0..0xA3 to 0x2000..0x200C alternate every cycle, and done pulses in cycle 9.
- Wait states: same copy with waitrequest high for 2 cycles on every access. Required: outputs stable throughout each stall, identical data written, done in cycle 25.
- Degenerate starts: L=0 gives done=1 and error=0 in cycle 1. src=0x1002 gives done=1 and error=1 in cycle 1. Neither case produces read or write activity.
- Start while busy: a second start with different addresses pulsed mid-copy is ignored, and the original copy completes with unchanged addresses.
- Reset mid-transfer: reset asserted during a stalled WR. Required: avm_write=0 and busy=0 on the next cycle, and a new copy started afterwards completes correctly.
- Wrap-around: src=0xFFFFFFF8, L=3. Required: reads at 0xFFFFFFF8, 0xFFFFFFFC and 0x00000000, with error=0.
